mem_port_arbiter: RTL and testbench

Memory-side responder for the pipelined core's two memory ports: the instruction-fetch port and the data load/store port. It accepts held-level requests from both ports and serialises them onto one single-ported physical memory interface with variable latency. It returns a one-cycle `resp` pulse with registered read data to the port that owns the completed transaction. It sits between the datapath and the cache or physical memory model and supplies the `inst_mem_resp` and `data_mem_resp` signals that the core's hazard unit stalls on.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises the instruction-fetch and data load/store
// ports onto one single-ported, variable-latency physical memory interface.
// Data requests win by default because they belong to the older instruction.
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive
// data grants with a fetch waiting, the next grant goes to the fetch.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_mem_read,
  input  logic [31:0] inst_mem_address,
  output logic [31:0] inst_mem_rdata,
  output logic        inst_mem_resp,
  input  logic        data_mem_read,
  input  logic        data_mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_wdata,
  output logic [31:0] data_mem_rdata,
  output logic        data_mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [3:0]  pmem_byte_enable,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {IDLE, INST, DATA, RESP} state_t;

  state_t state;
  logic   force_inst;
  logic   grant_data;
  logic   grant_inst;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  assign force_inst = inst_mem_read && (starve_cnt == LIMIT);

  // Count data grants made while a fetch waits; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_data) begin
        if (!inst_mem_read) begin
          starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else if (grant_inst) begin
        starve_cnt <= '0;
      end
    end
  end
`else
  logic unused_starve_limit;

  assign force_inst          = 1'b0;
  assign unused_starve_limit = ^STARVE_LIMIT;
`endif

  assign grant_data = (data_mem_read || data_mem_write) && !force_inst;
  assign grant_inst = inst_mem_read && !grant_data;

  // Arbitration FSM; the pmem_* registers double as the transaction latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_byte_enable <= '0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      inst_mem_rdata   <= '0;
      data_mem_rdata   <= '0;
      inst_mem_resp    <= 1'b0;
      data_mem_resp    <= 1'b0;
    end else begin
      inst_mem_resp <= 1'b0;
      data_mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            state            <= DATA;
            // read+write together is treated as a store
            pmem_write       <= data_mem_write;
            pmem_read        <= !data_mem_write;
            pmem_address     <= data_mem_address;
            pmem_wdata       <= data_mem_wdata;
            pmem_byte_enable <= data_mem_write ? mem_byte_enable : '1;
          end else if (grant_inst) begin
            state            <= INST;
            pmem_read        <= 1'b1;
            pmem_write       <= 1'b0;
            pmem_address     <= inst_mem_address;
            pmem_wdata       <= '0;
            pmem_byte_enable <= '1;
          end
        end
        INST: begin
          if (pmem_resp) begin
            state          <= RESP;
            pmem_read      <= 1'b0;
            pmem_write     <= 1'b0;
            inst_mem_resp  <= 1'b1;
            inst_mem_rdata <= pmem_rdata;
          end
        end
        DATA: begin
          if (pmem_resp) begin
            state         <= RESP;
            pmem_read     <= 1'b0;
            pmem_write    <= 1'b0;
            data_mem_resp <= 1'b1;
            if (!pmem_write) begin
              data_mem_rdata <= pmem_rdata;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_mem_read;
  logic [31:0] inst_mem_address;
  logic [31:0] inst_mem_rdata;
  logic        inst_mem_resp;
  logic        data_mem_read;
  logic        data_mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] data_mem_address;
  logic [31:0] data_mem_wdata;
  logic [31:0] data_mem_rdata;
  logic        data_mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk              (clk),
    .rst              (rst),
    .inst_mem_read    (inst_mem_read),
    .inst_mem_address (inst_mem_address),
    .inst_mem_rdata   (inst_mem_rdata),
    .inst_mem_resp    (inst_mem_resp),
    .data_mem_read    (data_mem_read),
    .data_mem_write   (data_mem_write),
    .mem_byte_enable  (mem_byte_enable),
    .data_mem_address (data_mem_address),
    .data_mem_wdata   (data_mem_wdata),
    .data_mem_rdata   (data_mem_rdata),
    .data_mem_resp    (data_mem_resp),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // physical memory contents, word indexed by address[9:2]
  logic [31:0] mem [0:255];

  // reference model: one outstanding transaction, then a one-cycle response gap
  bit          m_busy, m_gap, m_owner_data, m_op_write;
  int unsigned m_starve;
  logic        m_pread, m_pwrite, m_iresp, m_dresp;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  logic [3:0]  m_be;

  // stimulus knobs and responder state
  int unsigned p_inst, p_data, p_drop, lat_min, lat_max;
  bit          spurious_en;
  bit          r_pend;
  int unsigned r_lat;

  task automatic model_reset();
    m_busy = 0; m_gap = 0; m_owner_data = 0; m_op_write = 0; m_starve = 0;
    m_pread = 0; m_pwrite = 0; m_iresp = 0; m_dresp = 0;
    m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0; m_be = '0;
  endtask

  // Advance the model across one clock edge using the inputs seen before it.
  task automatic model_edge();
    bit dreq, ireq, force_i;
    m_iresp = 0;
    m_dresp = 0;
    dreq = data_mem_read || data_mem_write;
    ireq = inst_mem_read;
    if (m_busy) begin
      if (pmem_resp) begin
        m_busy = 0; m_gap = 1; m_pread = 0; m_pwrite = 0;
        if (m_owner_data) begin
          m_dresp = 1;
          if (!m_op_write) m_drdata = mem[m_addr[9:2]];
        end else begin
          m_iresp  = 1;
          m_irdata = mem[m_addr[9:2]];
        end
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      force_i = 0;
`ifdef ARB_STARVE_GUARD_EN
      force_i = ireq && (m_starve == LIMIT);
`endif
      if (dreq && !force_i) begin
        m_busy = 1; m_owner_data = 1; m_op_write = data_mem_write;
        m_pwrite = data_mem_write; m_pread = !data_mem_write;
        m_addr = data_mem_address; m_wdata = data_mem_wdata;
        m_be = data_mem_write ? mem_byte_enable : 4'hF;
        m_starve = ireq ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end else if (ireq) begin
        m_busy = 1; m_owner_data = 0; m_op_write = 0;
        m_pread = 1; m_pwrite = 0; m_addr = inst_mem_address; m_be = 4'hF;
        m_starve = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("pmem_read", pmem_read, m_pread);
    check_eq("pmem_write", pmem_write, m_pwrite);
    check_eq("inst_resp", inst_mem_resp, m_iresp);
    check_eq("data_resp", data_mem_resp, m_dresp);
    check_eq("inst_rdata", inst_mem_rdata, m_irdata);
    check_eq("data_rdata", data_mem_rdata, m_drdata);
    if (m_pread || m_pwrite) begin
      check_eq("pmem_address", pmem_address, m_addr);
      check_eq("pmem_be", pmem_byte_enable, m_be);
      if (m_pwrite) check_eq("pmem_wdata", pmem_wdata, m_wdata);
    end
  endtask

  task automatic drive_inputs();
    logic [31:0] w;
    int unsigned k;
    // memory responder
    pmem_resp = 1'b0;
    if (pmem_read || pmem_write) begin
      if (!r_pend) begin
        r_pend = 1;
        r_lat  = $urandom_range(lat_max, lat_min);
      end
      if (r_lat == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem[pmem_address[9:2]];
        if (pmem_write) begin
          w = mem[pmem_address[9:2]];
          for (int b = 0; b < 4; b++)
            if (pmem_byte_enable[b]) w[8*b +: 8] = pmem_wdata[8*b +: 8];
          mem[pmem_address[9:2]] = w;
        end
        r_pend = 0;
      end else begin
        r_lat--;
      end
    end else if (spurious_en && $urandom_range(7, 0) == 0) begin
      pmem_resp  = 1'b1;
      pmem_rdata = $urandom;
    end
    // fetch requester
    if (inst_mem_resp) begin
      inst_mem_read = 1'b0;
    end else if (inst_mem_read && $urandom_range(99, 0) < p_drop) begin
      inst_mem_read = 1'b0;
    end else if (!inst_mem_read && $urandom_range(99, 0) < p_inst) begin
      inst_mem_read    = 1'b1;
      inst_mem_address = {22'd0, 8'($urandom_range(255, 0)), 2'b00};
    end
    // load/store requester
    if (data_mem_resp) begin
      data_mem_read  = 1'b0;
      data_mem_write = 1'b0;
    end else if (!(data_mem_read || data_mem_write) && $urandom_range(99, 0) < p_data) begin
      k = $urandom_range(7, 0);
      data_mem_read    = (k < 4) || (k == 7);
      data_mem_write   = (k >= 4);
      mem_byte_enable  = 4'($urandom_range(15, 1));
      data_mem_wdata   = $urandom;
      data_mem_address = {22'd0, 8'($urandom_range(255, 0)), 2'b00};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_outputs();
    drive_inputs();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_pmem_read"}, pmem_read, 0);
    check_eq({tag, "_pmem_write"}, pmem_write, 0);
    check_eq({tag, "_inst_resp"}, inst_mem_resp, 0);
    check_eq({tag, "_data_resp"}, data_mem_resp, 0);
    check_eq({tag, "_pmem_address"}, pmem_address, 0);
    check_eq({tag, "_pmem_wdata"}, pmem_wdata, 0);
    check_eq({tag, "_pmem_be"}, pmem_byte_enable, 0);
    check_eq({tag, "_inst_rdata"}, inst_mem_rdata, 0);
    check_eq({tag, "_data_rdata"}, data_mem_rdata, 0);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_values({tag, "_async"});
    repeat (2) @(posedge clk);
    #1;
    check_reset_values({tag, "_held"});
    rst       = 1'b0;
    pmem_resp = 1'b0;
    r_pend    = 0;
    model_reset();
  endtask

  task automatic wait_resp(input bit data_port, input int unsigned budget, input string tag);
    bit seen;
    seen = 0;
    for (int unsigned k = 0; k < budget && !seen; k++) begin
      step();
      seen = data_port ? data_mem_resp : inst_mem_resp;
    end
    check_eq({tag, "_resp_seen"}, seen, 1);
  endtask

  task automatic drain();
    for (int unsigned k = 0; k < 100 &&
         (inst_mem_read || data_mem_read || data_mem_write || m_busy || m_gap); k++)
      step();
    check_eq("drain_idle", m_busy || m_gap || inst_mem_read || data_mem_read || data_mem_write, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d_at, i_at, wcnt, d_before;
    bit          i_seen;
    logic [31:0] prev;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h18] = 32'h00A00093;

    rst = 1'b1;
    inst_mem_read = 0; inst_mem_address = '0;
    data_mem_read = 0; data_mem_write = 0; mem_byte_enable = '0;
    data_mem_address = '0; data_mem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    p_inst = 0; p_data = 0; p_drop = 0; lat_min = 0; lat_max = 0; spurious_en = 0;
    @(posedge clk);
    #1;
    apply_reset("por");

    // lone fetch, zero-wait memory
    inst_mem_read = 1; inst_mem_address = 32'h60;
    step();
    check_eq("fetch_strobe", pmem_read, 1);
    check_eq("fetch_addr", pmem_address, 32'h60);
    step();
    check_eq("fetch_resp", inst_mem_resp, 1);
    check_eq("fetch_rdata", inst_mem_rdata, 32'h00A00093);
    step();
    check_eq("fetch_resp_pulse", inst_mem_resp, 0);

    // simultaneous fetch and load: data first
    inst_mem_read = 1; inst_mem_address = 32'h64;
    data_mem_read = 1; data_mem_write = 0; data_mem_address = 32'h100;
    d_at = 0; i_at = 0;
    for (int unsigned k = 1; k <= 8; k++) begin
      step();
      if (k == 4) begin
        check_eq("prio_fetch_strobe", pmem_read, 1);
        check_eq("prio_fetch_addr", pmem_address, 32'h64);
      end
      if (data_mem_resp && d_at == 0) d_at = k;
      if (inst_mem_resp && i_at == 0) i_at = k;
    end
    check_eq("prio_data_resp_cycle", d_at, 2);
    check_eq("prio_inst_resp_cycle", i_at, 5);

    // byte store with 5-cycle memory latency
    lat_min = 4; lat_max = 4;
    data_mem_read = 0; data_mem_write = 1; mem_byte_enable = 4'b0100;
    data_mem_wdata = 32'h00AB0000; data_mem_address = 32'h204;
    prev = m_drdata; wcnt = 0; d_at = 0;
    for (int unsigned k = 1; k <= 10; k++) begin
      step();
      if (pmem_write) begin
        wcnt++;
        check_eq("store_be", pmem_byte_enable, 4'b0100);
      end
      if (data_mem_resp && d_at == 0) d_at = k;
    end
    check_eq("store_write_cycles", wcnt, 5);
    check_eq("store_resp_cycle", d_at, 6);
    check_eq("store_rdata_kept", data_mem_rdata, prev);

    // continuous data traffic with the fetch held
    lat_min = 0; lat_max = 2; p_inst = 100; p_data = 100;
    inst_mem_read = 1; inst_mem_address = 32'h64;
    data_mem_read = 1; data_mem_write = 0; data_mem_address = 32'h100;
    d_before = 0; i_seen = 0;
    for (int unsigned k = 0; k < 120 && !i_seen && d_before < 12; k++) begin
      step();
      if (inst_mem_resp) i_seen = 1;
      else if (data_mem_resp) d_before++;
    end
`ifdef ARB_STARVE_GUARD_EN
    check_eq("guard_data_grants", d_before, LIMIT);
    check_eq("guard_inst_granted", i_seen, 1);
`else
    check_eq("strict_inst_granted", i_seen, 0);
    check_eq("strict_data_grants", d_before, 12);
`endif
    p_inst = 0; p_data = 0;
    drain();

    // reset two cycles into a 6-cycle read
    lat_min = 5; lat_max = 5;
    data_mem_read = 1; data_mem_write = 0; data_mem_address = 32'h300;
    step();
    step();
    check_eq("rst_pre_strobe", pmem_read, 1);
    apply_reset("mid");
    wait_resp(1, 30, "post_rst");
    check_eq("post_rst_rdata", data_mem_rdata, mem[8'hC0]);
    drain();

    // spurious pmem_resp while idle
    pmem_resp = 1; pmem_rdata = 32'hDEADBEEF;
    step();
    step();
    check_eq("spurious_inst_resp", inst_mem_resp, 0);
    check_eq("spurious_data_resp", data_mem_resp, 0);

    // read and write held together is a store
    lat_min = 1; lat_max = 1;
    data_mem_read = 1; data_mem_write = 1; mem_byte_enable = 4'b0011;
    data_mem_address = 32'h10; data_mem_wdata = 32'h12345678;
    step();
    check_eq("rw_pmem_write", pmem_write, 1);
    check_eq("rw_pmem_read", pmem_read, 0);
    check_eq("rw_pmem_be", pmem_byte_enable, 4'b0011);
    wait_resp(1, 20, "rw");
    drain();

    // randomized traffic
    p_inst = 35; p_data = 35; p_drop = 3; lat_min = 0; lat_max = 4; spurious_en = 1;
    for (int unsigned k = 0; k < 3000; k++) step();
    p_inst = 0; p_data = 0; p_drop = 0; spurious_en = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
